// File: rtl/filter_pkg.sv
// ============================================================================
//  Module   : filter_pkg
//  Purpose  : Shared geometry of the 3x3 filter: image size, padded line
//             width, frame size and the window tap offsets used by both the
//             padded frame writer and the window reader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_pkg;

    localparam int PIX_W       = 8;
    localparam int IMG_W       = 256;
    localparam int IMG_H       = 32;
    localparam int ADDR_W      = 14;

    // Padded geometry: one zero pixel on every side of the image
    localparam int PAD_W       = IMG_W + 2;
    localparam int FRAME_WORDS = PAD_W * (IMG_H + 2);

    // Window tap offsets relative to the top-left tap of a 3x3 window
    localparam int TAP_COL_0   = 0;
    localparam int TAP_COL_1   = 1;
    localparam int TAP_COL_2   = 2;
    localparam int TAP_ROW_1   = PAD_W;
    localparam int TAP_ROW_2   = 2 * PAD_W;

    // Buffer address of raw pixel (row, col) once the border is added
    function automatic int pad_addr(input int row, input int col);
        return (row + 1) * PAD_W + (col + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/padded_frame_writer.sv
// ============================================================================
//  Module   : padded_frame_writer
//  Purpose  : Write side of the 3x3 window buffer. Accepts a raw raster pixel
//             stream and writes it into the buffer surrounded by a one-pixel
//             zero border, one word per cycle, starting at address 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module padded_frame_writer #(
    parameter int PIX_W  = filter_pkg::PIX_W,
    parameter int IMG_W  = filter_pkg::IMG_W,
    parameter int IMG_H  = filter_pkg::IMG_H,
    parameter int ADDR_W = filter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              busy,
    output logic              frame_done
);

    import filter_pkg::*;

    localparam int LINE_W = IMG_W + 2;

    localparam int COL_CW = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
    localparam int ROW_CW = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
    localparam int PAD_CW = $clog2(LINE_W);

    localparam logic [COL_CW-1:0] COL_LAST = COL_CW'(IMG_W - 1);
    localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(IMG_H - 1);
    localparam logic [PAD_CW-1:0] PAD_LAST = PAD_CW'(LINE_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TOP   = 3'd1;
    localparam logic [2:0] S_LEFT  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_RIGHT = 3'd4;
    localparam logic [2:0] S_BOT   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [COL_CW-1:0] col_cnt;
    logic [ROW_CW-1:0] row_cnt;
    logic [PAD_CW-1:0] pad_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              wr_en;
    logic [PIX_W-1:0]  wr_data;
    logic              accept;

    assign accept = in_valid && in_ready;

    // State register; reset abandons any partial frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: walk top border, then per row left pad / pixels / right pad, then bottom border
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_TOP;
            S_TOP:   if (pad_cnt == PAD_LAST) state_nxt = S_LEFT;
            S_LEFT:  state_nxt = S_DATA;
            S_DATA:  if (accept && (col_cnt == COL_LAST)) state_nxt = S_RIGHT;
            S_RIGHT: state_nxt = (row_cnt == ROW_LAST) ? S_BOT : S_LEFT;
            S_BOT:   if (pad_cnt == PAD_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs per state: pad states always write zero, DATA writes only on a handshake
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        case (state)
            S_TOP, S_LEFT, S_RIGHT, S_BOT: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            S_DATA: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                wr_en    = in_valid;
                wr_data  = in_pixel;
            end
            S_DONE: frame_done = 1'b1;
            default: ;
        endcase
    end

    // Position counters; each wraps to 0 on the transition that leaves its phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if ((state == S_TOP) || (state == S_BOT)) begin
                pad_cnt <= (pad_cnt == PAD_LAST) ? '0 : pad_cnt + PAD_CW'(1);
            end
            if (accept) begin
                col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + COL_CW'(1);
            end
            if (state == S_RIGHT) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_CW'(1);
            end
        end
    end

    // Registered write port; the address advances only on cycles that write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_cnt  <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= addr_cnt;
                mem_wdata <= wr_data;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
            end else if (state == S_IDLE) begin
                addr_cnt  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_padded_frame_writer.sv
// ============================================================================
//  Module   : tb_padded_frame_writer
//  Purpose  : Self-checking bench for padded_frame_writer. A padded-image
//             model (address -> border zero or source pixel) is compared with
//             every write the default-size writer emits; a small 4x2 instance
//             is compared with a hand-written image.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_padded_frame_writer;

    localparam int IW    = 256;
    localparam int IH    = 32;
    localparam int PADW  = IW + 2;
    localparam int FW    = PADW * (IH + 2);
    localparam int NPIX  = IW * IH;
    localparam int S_FW  = (4 + 2) * (2 + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, in_ready, mem_we, busy, frame_done;
    logic [7:0]  in_pixel, mem_wdata;
    logic [13:0] mem_addr;

    logic        s_start, s_valid, s_ready, s_we, s_busy, s_done;
    logic [7:0]  s_pixel, s_wdata;
    logic [4:0]  s_addr;

    padded_frame_writer #(.PIX_W(8), .IMG_W(IW), .IMG_H(IH), .ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_pixel(in_pixel), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .frame_done(frame_done)
    );

    padded_frame_writer #(.PIX_W(8), .IMG_W(4), .IMG_H(2), .ADDR_W(5)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
        .in_ready(s_ready), .in_pixel(s_pixel), .mem_we(s_we),
        .mem_addr(s_addr), .mem_wdata(s_wdata), .busy(s_busy),
        .frame_done(s_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference image: source pixels plus the padded layout rule
    logic [7:0] pix [NPIX];
    logic [7:0] img [FW];

    function automatic logic [7:0] model_word(input int a);
        int r, c;
        r = a / PADW;
        c = a % PADW;
        if (r == 0 || r == IH + 1 || c == 0 || c == PADW - 1) return 8'h00;
        return pix[(r - 1) * IW + (c - 1)];
    endfunction

    bit check_en = 1'b0;
    int exp_addr, writes, gaps, done_cnt, after_gap_addr, first_addr, first_data;
    bit prev_gap;

    // Compare process for the default-size writer
    always @(negedge clk) begin
        if (check_en) begin
            if (mem_we) begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_addr));
                chk("wr_data", 32'(mem_wdata), 32'(model_word(exp_addr)));
                if (writes == 0) begin
                    first_addr = int'(mem_addr);
                    first_data = int'(mem_wdata);
                end
                if (prev_gap && after_gap_addr < 0) after_gap_addr = int'(mem_addr);
                if (int'(mem_addr) < FW) img[mem_addr] = mem_wdata;
                exp_addr++;
                writes++;
                prev_gap = 1'b0;
            end else if (writes > 0 && writes < FW) begin
                gaps++;
                prev_gap = 1'b1;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_writes", 32'(writes), 32'(FW));
                chk("done_last_write", {17'd0, mem_we, mem_addr}, {17'd0, 1'b1, 14'(FW - 1)});
                chk("done_busy", 32'(busy), 32'd0);
            end
            if (!busy && !frame_done) chk("idle_quiet", {30'd0, in_ready, mem_we}, 32'd0);
        end
    end

    // Capture for the small instance
    logic [7:0] s_img [S_FW];
    int s_writes = 0;
    always @(negedge clk) begin
        if (s_we) begin
            chk("small_addr", 32'(s_addr), 32'(s_writes));
            if (s_writes < S_FW) s_img[s_writes] = s_wdata;
            s_writes++;
        end
    end

    // mode 0: in_valid always high, pixel = index & 0xFF
    // mode 1: as mode 0 but 5 idle cycles after pixel (3,100)
    // mode 2: random pixels, random in_valid, stray start pulses while busy and in DONE
    task automatic run_frame(input int mode, input int abort_at);
        int idx, stall_left, cyc, stalls;
        bit hold_start;
        for (int i = 0; i < NPIX; i++) pix[i] = (mode == 2) ? 8'($urandom) : 8'(i);
        exp_addr = 0; writes = 0; gaps = 0; done_cnt = 0; prev_gap = 1'b0;
        after_gap_addr = -1; first_addr = -1; first_data = -1;
        check_en = 1'b1;
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; stall_left = 0; cyc = 0; stalls = 0; hold_start = 1'b0;
        while (done_cnt == 0 && cyc < 40000) begin
            case (mode)
                1:       in_valid = (stall_left == 0);
                2:       in_valid = ($urandom_range(0, 3) != 0);
                default: in_valid = 1'b1;
            endcase
            in_pixel = (idx < NPIX) ? pix[idx] : 8'($urandom);
            start    = hold_start || (mode == 2 && $urandom_range(0, 199) == 0);
            @(negedge clk);
            if (in_ready && in_valid) begin
                idx++;
                if (mode == 1 && idx == 3 * IW + 101) stall_left = 5;
            end else if (in_ready) begin
                stalls++;
                if (stall_left > 0) stall_left--;
            end
            if (mode == 2 && idx == NPIX) hold_start = 1'b1;
            if (abort_at > 0 && writes >= abort_at) break;
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (abort_at == 0) begin
            if (done_cnt == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL frame_timeout: no frame_done after %0d cycles, writes=%0d", cyc, writes);
            end
            repeat (20) @(posedge clk);
            #1;
            chk("one_frame_done", 32'(done_cnt), 32'd1);
            chk("busy_after_frame", 32'(busy), 32'd0);
            chk("total_writes", 32'(writes), 32'(FW));
            chk("gap_cycles", 32'(gaps), 32'(stalls));
        end
    endtask

    logic [7:0] s_exp [S_FW];
    int s_idx;
    bit s_seen_done;

    initial begin
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_pixel = 8'hA5;
        s_start = 1'b0; s_valid = 1'b0; s_pixel = 8'h00;

        // Reset dominates start and in_valid
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs", {6'd0, mem_we, mem_addr, mem_wdata, in_ready, busy, frame_done}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b1;

        // in_valid in IDLE is ignored
        repeat (4) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_no_write", 32'(mem_we), 32'd0);
        end
        @(posedge clk); #1;

        // Full frame, pixel=(row*256+col)&0xFF
        run_frame(0, 0);
        chk("pin_addr0",    32'(img[0]),    32'h00);
        chk("pin_addr258",  32'(img[258]),  32'h00);
        chk("pin_addr259",  32'(img[259]),  32'h00);
        chk("pin_addr260",  32'(img[260]),  32'h01);
        chk("pin_addr514",  32'(img[514]),  32'hFF);
        chk("pin_addr515",  32'(img[515]),  32'h00);
        chk("pin_addr516",  32'(img[516]),  32'h00);
        chk("pin_addr517",  32'(img[517]),  32'h00);
        chk("pin_addr518",  32'(img[518]),  32'h01);
        chk("pin_addr8514", 32'(img[8514]), 32'h00);
        chk("pin_addr8771", 32'(img[8771]), 32'h00);
        chk("pin_gaps",     32'(gaps),      32'd0);

        // Five-cycle stall after pixel (3,100); next write is pixel (3,101)
        run_frame(1, 0);
        chk("stall_gaps",        32'(gaps),           32'd5);
        chk("stall_resume_addr", 32'(after_gap_addr), 32'd1134);
        chk("stall_resume_data", 32'(img[1134]),      32'(8'(3 * 256 + 101)));

        // Random data, random in_valid, ignored start pulses
        run_frame(2, 0);

        // Reset mid-frame, then a fresh frame from address 0
        run_frame(0, 4000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        check_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs", {6'd0, mem_we, mem_addr, mem_wdata, in_ready, busy, frame_done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0);
        chk("restart_first_addr", 32'(first_addr), 32'd0);
        chk("restart_first_data", 32'(first_data), 32'd0);

        // Small 4x2 instance with pixels 1..8
        s_exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                  8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0,
                  8'd5, 8'd6, 8'd7, 8'd8,
                  8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        s_writes = 0;
        s_idx = 0;
        s_seen_done = 1'b0;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !s_seen_done; cyc++) begin
            s_valid = 1'b1;
            s_pixel = 8'(s_idx + 1);
            @(negedge clk);
            if (s_ready) s_idx++;
            if (s_done) s_seen_done = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("small_done_seen", 32'(s_seen_done), 32'd1);
        chk("small_writes",    32'(s_writes),    32'(S_FW));
        for (int i = 0; i < S_FW; i++) chk($sformatf("small_img[%0d]", i), 32'(s_img[i]), 32'(s_exp[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
